// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that serialises instruction fetches (port 0) and data
// accesses (port 1) onto the single port of the shared unified memory.
module mem_port_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MEM_BYTES    = 65536
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_datain,
    output logic        mem_wr,
    input  logic [31:0] mem_dataout
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                busy_q, busy_d;
    logic                if_ack_q, if_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_err_q, if_err_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_err_q, d_err_d;

    logic                win;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_bad;

    // Next-state, grant and completion logic
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        wr_d       = 1'b0;
        if_ack_d   = 1'b0;
        if_rdata_d = '0;
        if_err_d   = 1'b0;
        d_ack_d    = 1'b0;
        d_rdata_d  = '0;
        d_err_d    = 1'b0;

        // A lone requester wins; on contention the pointer names the winner
        win      = (if_req && d_req) ? prio_q : d_req;
        sel_addr = win ? d_addr : if_addr;
        sel_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr > MAX_ADDR);

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d = win;
                    prio_d  = ~win;
                    we_d    = win & d_we;
                    addr_d  = sel_addr;
                    wdata_d = win ? d_wdata : '0;
                    cnt_d   = '0;
                    if (sel_bad) begin
                        state_d  = DONE;
                        if_ack_d = ~win;
                        if_err_d = ~win;
                        d_ack_d  = win;
                        d_err_d  = win;
                    end else begin
                        state_d = ACCESS;
                        wr_d    = win & d_we;
                    end
                end
            end
            ACCESS: begin
                if (we_q || (cnt_q == CNT_LAST)) begin
                    state_d  = DONE;
                    if_ack_d = ~owner_q;
                    d_ack_d  = owner_q;
                    if (!we_q) begin
                        if_rdata_d = owner_q ? '0 : mem_dataout;
                        d_rdata_d  = owner_q ? mem_dataout : '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            if_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            if_err_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
            d_err_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            if_ack_q   <= if_ack_d;
            if_rdata_q <= if_rdata_d;
            if_err_q   <= if_err_d;
            d_ack_q    <= d_ack_d;
            d_rdata_q  <= d_rdata_d;
            d_err_q    <= d_err_d;
        end
    end

    assign if_ack     = if_ack_q;
    assign if_rdata   = if_rdata_q;
    assign if_err     = if_err_q;
    assign d_ack      = d_ack_q;
    assign d_rdata    = d_rdata_q;
    assign d_err      = d_err_q;
    assign busy       = busy_q;
    assign mem_raddr  = addr_q;
    assign mem_waddr  = addr_q;
    assign mem_datain = wdata_q;
    // Gate with reset so a write aborted by reset never reaches memory
    assign mem_wr     = wr_q & nrst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed port drivers push expected responses,
// a negedge monitor pops and compares them against each ack.
module tb_mem_port_arbiter;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        busy;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_datain;
    logic        mem_wr;
    logic [31:0] mem_dataout;

    logic [31:0] mem [0:16383];
    exp_t        if_q[$];
    exp_t        d_q[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_seen = 0;
    int          wr0;
    logic        alt_on = 1'b0;
    logic        have_last = 1'b0;
    logic        last_port = 1'b0;

    mem_port_arbiter #(.READ_LATENCY(1), .MEM_BYTES(65536)) dut (
        .clk(clk), .nrst(nrst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err), .busy(busy),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_datain(mem_datain),
        .mem_wr(mem_wr), .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory with one cycle of registered read latency
    always @(posedge clk) begin
        if (mem_wr) mem[mem_waddr[15:2]] <= mem_datain;
        mem_dataout <= mem[mem_raddr[15:2]];
    end

    always @(negedge clk) if (mem_wr) wr_seen <= wr_seen + 1;

    function automatic logic [31:0] pre(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive_if(input logic [31:0] addr, input logic [31:0] rdata_exp,
                            input logic err_exp, input int lat);
        exp_t e;
        int   n;
        if_req  = 1'b1;
        if_addr = addr;
        e.rdata = rdata_exp;
        e.err   = err_exp;
        e.cyc   = cyc + lat;
        if_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!if_ack && n < 60);
        if (!if_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL if_ack_timeout: no ack after %0d cycles for addr 0x%08h, required an ack", n, addr);
        end
        if_req = 1'b0;
    endtask

    task automatic drive_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata_exp, input logic err_exp, input int lat);
        exp_t e;
        int   n;
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = addr;
        d_wdata = wdata;
        e.rdata = rdata_exp;
        e.err   = err_exp;
        e.cyc   = cyc + lat;
        d_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!d_ack && n < 60);
        if (!d_ack) begin
            n_tests++;
            n_fail++;
            $display("FAIL d_ack_timeout: no ack after %0d cycles for addr 0x%08h, required an ack", n, addr);
        end
        d_req = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (if_ack || d_ack) chk("single_ack", 32'(if_ack & d_ack), 32'd0);
        if (if_ack) begin
            if (if_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL if_spurious_ack: got ack at cycle %0d, required none", cyc);
            end else begin
                mon_e = if_q.pop_front();
                chk("if_rdata", if_rdata, mon_e.rdata);
                chk("if_err", 32'(if_err), 32'(mon_e.err));
                chk("if_ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            if (alt_on && have_last) chk("alt_port", 32'd0, 32'(!last_port));
            last_port = 1'b0;
            have_last = alt_on;
        end
        if (d_ack) begin
            if (d_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL d_spurious_ack: got ack at cycle %0d, required none", cyc);
            end else begin
                mon_e = d_q.pop_front();
                chk("d_rdata", d_rdata, mon_e.rdata);
                chk("d_err", 32'(d_err), 32'(mon_e.err));
                chk("d_ack_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
            if (alt_on && have_last) chk("alt_port", 32'd1, 32'(!last_port));
            last_port = 1'b1;
            have_last = alt_on;
        end
        if (!alt_on) have_last = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst    = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        for (int i = 0; i < 16384; i++) mem[i] = pre(i);
        @(negedge clk);

        // Reset held 3 cycles with both requesters active; port 0 wins first
        fork
            drive_if(32'h20, pre(8), 1'b0, 6);
            drive_d(1'b0, 32'h24, 32'h0, pre(9), 1'b0, 10);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("rst_ctrl", 32'({if_ack, d_ack, if_err, d_err, busy, mem_wr}), 32'd0);
                    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
                    chk("rst_mem_bus", mem_raddr | mem_waddr | mem_datain, 32'd0);
                end
                nrst = 1'b1;
            end
        join

        // Sequential fetches spaced READ_LATENCY+3 cycles apart
        @(negedge clk);
        for (int i = 0; i <= 16; i++) drive_if(32'(i * 4), pre(i), 1'b0, (i == 0) ? 3 : 4);

        // Data write then read-back
        @(negedge clk);
        fork
            drive_d(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
            begin
                @(negedge clk);
                chk("wr_pulse", 32'(mem_wr), 32'd1);
                chk("wr_waddr", mem_waddr, 32'h10);
                chk("wr_datain", mem_datain, 32'hDEAD_BEEF);
                @(negedge clk);
                chk("wr_pulse_end", 32'(mem_wr), 32'd0);
            end
        join
        drive_d(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);

        // Error grants never touch memory; last legal word still works
        @(negedge clk);
        wr0 = wr_seen;
        drive_d(1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
        drive_d(1'b0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 2);
        drive_d(1'b1, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
        drive_if(32'h2, 32'h0, 1'b1, 2);
        chk("err_no_write", 32'(wr_seen - wr0), 32'd0);
        drive_d(1'b0, 32'hFFFC, 32'h0, pre(16383), 1'b0, 4);

        // Back-to-back contention alternates grants starting with port 0
        @(negedge clk);
        alt_on = 1'b1;
        fork
            begin
                drive_if(32'h0, pre(0), 1'b0, 3);
                drive_if(32'h4, pre(1), 1'b0, 8);
                drive_if(32'h8, pre(2), 1'b0, 8);
            end
            begin
                drive_d(1'b0, 32'h100, 32'h0, pre(64), 1'b0, 7);
                drive_d(1'b0, 32'h104, 32'h0, pre(65), 1'b0, 8);
                drive_d(1'b0, 32'h108, 32'h0, pre(66), 1'b0, 8);
            end
        join
        alt_on = 1'b0;

        // Reset during the write cycle aborts the write and the transaction
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("abort_wr_before", 32'(mem_wr), 32'd1);
        chk("abort_busy_before", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        chk("abort_wr_gated", 32'(mem_wr), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", 32'(busy), 32'd0);
        chk("abort_no_ack", 32'(d_ack), 32'd0);
        chk("abort_mem_intact", mem[16], pre(16));
        nrst = 1'b1;
        repeat (4) @(negedge clk);

        chk("if_queue_drained", 32'(if_q.size()), 32'd0);
        chk("d_queue_drained", 32'(d_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter and access sequencer for the shared 32-bit unified memory (Memoria32) of the multicycle RISC-V core. It serialises instruction-fetch reads (port 0) and load/store accesses (port 1) onto the memory's single read/write port using round-robin arbitration. It drives the memory's raddress, waddress, Datain and Wr inputs and accounts for the memory's read latency. It flags misaligned or out-of-range accesses without touching memory.

## Interface
- READ_LATENCY, 1: cycles from mem_raddr stable to valid mem_dataout (0 = combinational read).
- MEM_BYTES, 65536: addressable bytes; legal addresses are 0 .. MEM_BYTES-4.
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  reset; synchronous, active-low.
- if_req  in  1  port 0 read request; held with if_addr until if_ack.
- if_addr  in  32  port 0 byte address.
- if_ack  out  1  one-cycle completion pulse, port 0.
- if_rdata  out  32  port 0 read data, valid while if_ack=1.
- if_err  out  1  port 0 error, valid while if_ack=1.
- d_req  in  1  port 1 request; held with d_we/d_addr/d_wdata until d_ack.
- d_we  in  1  port 1: 1 = write, 0 = read.
- d_addr  in  32  port 1 byte address.
- d_wdata  in  32  port 1 write data.
- d_ack  out  1  one-cycle completion pulse, port 1.
- d_rdata  out  32  port 1 read data, valid while d_ack=1.
- d_err  out  1  port 1 error, valid while d_ack=1.
- busy  out  1  high in every state except IDLE.
- mem_raddr  out  32  memory read address.
- mem_waddr  out  32  memory write address.
- mem_datain  out  32  memory write data.
- mem_wr  out  1  memory write enable.
- mem_dataout  in  32  memory read data.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any req, pick a winner and latch owner, we (forced 0 for port 0), addr and wdata.
  - Legal address → ACCESS.
  - addr[1:0]≠0 or addr>MEM_BYTES-4 → DONE with err=1; memory untouched.
- Arbitration is round-robin with a 1-bit priority pointer.
  - Pointer resets to port 0 and flips to the non-winner on every grant, including error grants.
  - With a single requester, that requester wins regardless of the pointer.
- ACCESS write: exactly one cycle with mem_wr=1, mem_waddr=addr, mem_datain=wdata → DONE.
- ACCESS read: mem_raddr=addr for READ_LATENCY+1 cycles, counted by a latency counter. mem_dataout is captured into the read-data register at the end of the last cycle → DONE.
- DONE: ack of the owner =1 for one cycle with rdata/err; other port's ack=0 → IDLE.
- rdata is zero for writes and errors. err is 0 on success.
- mem_raddr, mem_waddr and mem_datain hold the latched values outside ACCESS.
- mem_wr = (ACCESS & we) & nrst, so no write commits in a cycle where nrst=0.
- A requester may drop or change req in or after its ack cycle. req high in the following IDLE is a new transaction.
- Changing req fields before ack is illegal and the result is undefined; the latched copy is used.

## Timing
- Reset (nrst=0 at a rising edge): state=IDLE, pointer=port 0, counter=0, all outputs 0, including mem_raddr/mem_waddr/mem_datain/mem_wr and both ack/rdata/err.
- Reset mid-transaction aborts it: no ack is issued and the requester must re-request.
- Edge E0 is the edge at which IDLE samples req.
- Write: mem_wr=1 in cycle E0+1; ack in cycle E0+2; IDLE in cycle E0+3.
- Read: mem_raddr valid in cycles E0+1 .. E0+1+READ_LATENCY; ack in cycle E0+2+READ_LATENCY.
- Error: ack with err=1 in cycle E0+1.
- Throughput: one transaction per 3 cycles (write) or READ_LATENCY+3 cycles (read).
- Simultaneous requests in IDLE: the pointer decides; the loser waits exactly one transaction.
- Under back-to-back contention, grants strictly alternate.

## Test plan
- Reset: hold nrst=0 for 3 cycles with both req high → all outputs 0, no ack; after release, port 0 granted first.
- Port 1 write 0xDEADBEEF to 0x10, then read 0x10 (READ_LATENCY=1) → mem_wr pulse at E0+1 with waddr 0x10; read d_ack at E0+3 with d_rdata=0xDEADBEEF.
- Both req held continuously for 6 transactions → acks alternate 0,1,0,1,0,1; never both acks in the same cycle.
- Port 1 read at 0x13 and at MEM_BYTES → d_ack at E0+1 with d_err=1, d_rdata=0, mem_wr never asserted.
- nrst dropped during the ACCESS write cycle → mem_wr=0 that cycle, memory at target unchanged, no d_ack, busy=0 next cycle.
- Port 0 fetches 0,4,...,64 sequentially → each if_rdata equals preloaded memory contents; ack spacing is READ_LATENCY+3 cycles.
